grill_slot: RTL and testbench

Per-slot cooking state machine for the grill playfield, sitting directly downstream of the rate divider. It consumes the divider's terminal-count tick, which is one tick per game time unit at the speed the rate mux selects, and the player's place/flip/serve strobes. It tracks which side of the item is cooking and how far it has overcooked. On serve it emits a one-cycle score, which feeds the score accumulator and the VGA slot renderer.

---
 rtl/grill_pkg.sv | 15 +
 rtl/grill_tick_edge.sv | 21 ++
 rtl/grill_slot.sv | 114 +++++++++++
 tb/tb_grill_slot.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/grill_pkg.sv
// rtl/grill_pkg.sv - grill slot state encoding and default cook/score parameters
package grill_pkg;

  localparam logic [2:0] ST_EMPTY  = 3'd0;
  localparam logic [2:0] ST_SIDE_A = 3'd1;
  localparam logic [2:0] ST_SIDE_B = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_BURNT  = 3'd4;

  localparam int DEF_COOK_TICKS = 4;
  localparam int DEF_BURN_TICKS = 3;
  localparam int DEF_BASE_SCORE = 100;
  localparam int DEF_PENALTY    = 20;

endpackage

// File: rtl/grill_tick_edge.sv
// rtl/grill_tick_edge.sv - registered rising-edge detector for a level tick
module grill_tick_edge (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/grill_slot.sv
// rtl/grill_slot.sv - per-slot cooking FSM with serve scoring
// GRILL_TICK_EDGE_EN: count only rising edges of tick (one extra cycle of latency).
module grill_slot
  import grill_pkg::*;
#(
  parameter int COOK_TICKS = DEF_COOK_TICKS,
  parameter int BURN_TICKS = DEF_BURN_TICKS,
  parameter int BASE_SCORE = DEF_BASE_SCORE,
  parameter int PENALTY    = DEF_PENALTY,
  parameter int SCORE_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               place,
  input  logic               flip,
  input  logic               serve,
  output logic [2:0]         state,
  output logic [3:0]         cook_cnt,
  output logic [3:0]         over_cnt,
  output logic               score_valid,
  output logic [SCORE_W-1:0] score
);

  localparam int PW = SCORE_W + 4;
  localparam logic [3:0] COOK_MAX = 4'(COOK_TICKS);
  localparam logic [3:0] BURN_MAX = 4'(BURN_TICKS);

  logic cook_tick;

`ifdef GRILL_TICK_EDGE_EN
  grill_tick_edge u_tick_edge (
    .clock (clock),
    .reset (reset),
    .level (tick),
    .pulse (cook_tick)
  );
`else
  assign cook_tick = tick;
`endif

  logic [3:0]         over_nxt;
  logic [3:0]         cook_nxt;
  logic [PW-1:0]      penalty_prod;
  logic [PW-1:0]      base_ext;
  logic [SCORE_W-1:0] serve_score;

  assign over_nxt     = over_cnt + 4'd1;
  assign cook_nxt     = cook_cnt + 4'd1;
  assign penalty_prod = PW'(over_cnt) * PW'(PENALTY);
  assign base_ext     = PW'(BASE_SCORE);

  // Saturating subtract: a heavily overcooked item scores zero rather than wrapping.
  always_comb begin
    serve_score = '0;
    if (state == ST_DONE && base_ext > penalty_prod) begin
      serve_score = SCORE_W'(base_ext - penalty_prod);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_EMPTY;
      cook_cnt    <= 4'd0;
      over_cnt    <= 4'd0;
      score_valid <= 1'b0;
      score       <= '0;
    end else begin
      score_valid <= 1'b0;
      case (state)
        ST_EMPTY: begin
          if (place) begin
            state    <= ST_SIDE_A;
            cook_cnt <= 4'd0;
            over_cnt <= 4'd0;
          end
        end
        ST_SIDE_A: begin
          if (flip && cook_cnt == COOK_MAX) begin
            state    <= ST_SIDE_B;
            cook_cnt <= 4'd0;
          end else if (cook_tick) begin
            if (cook_cnt < COOK_MAX) begin
              cook_cnt <= cook_nxt;
            end else begin
              over_cnt <= over_nxt;
              if (over_nxt == BURN_MAX) state <= ST_BURNT;
            end
          end
        end
        ST_SIDE_B: begin
          if (cook_tick) begin
            cook_cnt <= cook_nxt;
            if (cook_nxt == COOK_MAX) state <= ST_DONE;
          end
        end
        ST_DONE, ST_BURNT: begin
          if (serve) begin
            state       <= ST_EMPTY;
            cook_cnt    <= 4'd0;
            over_cnt    <= 4'd0;
            score_valid <= 1'b1;
            score       <= serve_score;
          end else if (cook_tick && state == ST_DONE) begin
            over_cnt <= over_nxt;
            if (over_nxt == BURN_MAX) state <= ST_BURNT;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_grill_slot.sv
// tb/tb_grill_slot.sv - directed and randomized check of grill_slot against a behavioural model
module tb_grill_slot;

  localparam int CK   = 2;
  localparam int BT   = 3;
  localparam int BASE = 100;
  localparam int PEN  = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, place = 1'b0, flip = 1'b0, serve = 1'b0;
  logic [2:0] state;
  logic [3:0] cook_cnt, over_cnt;
  logic       score_valid;
  logic [7:0] score;

  int total = 0;
  int bad   = 0;

  // model: 0 empty, 1 side A, 2 side B, 3 done, 4 burnt
  int m_state = 0, m_cook = 0, m_over = 0, m_valid = 0, m_score = 0;
  bit m_prev = 0, m_pulse = 0;

  always #5 clock = ~clock;

  grill_slot #(
    .COOK_TICKS (CK),
    .BURN_TICKS (BT),
    .BASE_SCORE (BASE),
    .PENALTY    (PEN),
    .SCORE_W    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .place       (place),
    .flip        (flip),
    .serve       (serve),
    .state       (state),
    .cook_cnt    (cook_cnt),
    .over_cnt    (over_cnt),
    .score_valid (score_valid),
    .score       (score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic add_over();
    m_over++;
    if (m_over >= BT) m_state = 4;
  endtask

  task automatic model_edge(input bit r, input bit t, input bit p, input bit f, input bit s);
    bit te;
`ifdef GRILL_TICK_EDGE_EN
    te = m_pulse;
    m_pulse = r ? 1'b0 : (t & ~m_prev);
    m_prev  = r ? 1'b0 : t;
`else
    te = t;
`endif
    m_valid = 0;
    if (r) begin
      m_state = 0; m_cook = 0; m_over = 0; m_score = 0;
    end else if (m_state == 0) begin
      if (p) begin m_state = 1; m_cook = 0; m_over = 0; end
    end else if (m_state == 3 || m_state == 4) begin
      if (s) begin
        m_score = (m_state == 4) ? 0 : ((BASE - m_over * PEN) > 0 ? BASE - m_over * PEN : 0);
        m_valid = 1; m_state = 0; m_cook = 0; m_over = 0;
      end else if (te && m_state == 3) begin
        add_over();
      end
    end else if (m_state == 1 && f && m_cook == CK) begin
      m_state = 2; m_cook = 0;
    end else if (te) begin
      if (m_state == 2) begin
        m_cook++;
        if (m_cook == CK) m_state = 3;
      end else if (m_cook < CK) m_cook++;
      else add_over();
    end
  endtask

  task automatic step(input string tag, input bit r, input bit t, input bit p, input bit f, input bit s);
    reset = r; tick = t; place = p; flip = f; serve = s;
    @(posedge clock);
    model_edge(r, t, p, f, s);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".cook"}, 32'(cook_cnt), 32'(m_cook));
    chk({tag, ".over"}, 32'(over_cnt), 32'(m_over));
    chk({tag, ".valid"}, 32'(score_valid), 32'(m_valid));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 0, 1, 0, 0, 0);
      step(tag, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // reset state
    step("reset", 1, 0, 0, 0, 0);
    chk("reset_state", 32'(state), 32'd0);

    // perfect cook
    step("pc_place", 0, 0, 1, 0, 0);
    ticks("pc_a", 2);
    step("pc_flip", 0, 0, 0, 1, 0);
    ticks("pc_b", 2);
    chk("pc_done", 32'(state), 32'd3);
    step("pc_serve", 0, 0, 0, 0, 1);
    chk("pc_score", 32'(score), 32'd100);
    chk("pc_valid", 32'(score_valid), 32'd1);
    step("pc_idle", 0, 0, 0, 0, 0);
    chk("pc_valid_drop", 32'(score_valid), 32'd0);

    // overcook
    step("oc_place", 0, 0, 1, 0, 0);
    ticks("oc_a", 3);
    chk("oc_over1", 32'(over_cnt), 32'd1);
    step("oc_flip", 0, 0, 0, 1, 0);
    ticks("oc_b", 3);
    chk("oc_over2", 32'(over_cnt), 32'd2);
    step("oc_serve", 0, 0, 0, 0, 1);
    chk("oc_score", 32'(score), 32'd60);

    // burn
    step("bn_place", 0, 0, 1, 0, 0);
    ticks("bn_a", 5);
    chk("bn_state", 32'(state), 32'd4);
    chk("bn_over", 32'(over_cnt), 32'd3);
    ticks("bn_more", 2);
    chk("bn_hold", 32'(over_cnt), 32'd3);
    step("bn_serve", 0, 0, 0, 0, 1);
    chk("bn_score", 32'(score), 32'd0);
    chk("bn_valid", 32'(score_valid), 32'd1);

    // rejected commands, then serve+tick in DONE
    step("rj_place", 0, 0, 1, 0, 0);
    ticks("rj_a", 1);
    step("rj_early_flip", 0, 0, 0, 1, 0);
    chk("rj_flip_state", 32'(state), 32'd1);
    ticks("rj_a2", 1);
    step("rj_flip", 0, 0, 0, 1, 0);
    step("rj_serve_b", 0, 0, 0, 0, 1);
    chk("rj_no_valid", 32'(score_valid), 32'd0);
    ticks("rj_b", 2);
    step("rj_place_done", 0, 0, 1, 0, 0);
    chk("rj_done_kept", 32'(state), 32'd3);
    step("st_serve_tick", 0, 1, 0, 0, 1);
    chk("st_score", 32'(score), 32'd100);
    step("st_idle", 0, 0, 0, 0, 0);

    // reset during SIDE_B
    step("rs_place", 0, 0, 1, 0, 0);
    ticks("rs_a", 2);
    step("rs_flip", 0, 0, 0, 1, 0);
    ticks("rs_b", 1);
    step("rs_reset", 1, 0, 0, 0, 0);
    chk("rs_state", 32'(state), 32'd0);
    chk("rs_score", 32'(score), 32'd0);

    // tick held high for five cycles
    step("lv_place", 0, 0, 1, 0, 0);
    step("lv_hold0", 0, 1, 0, 0, 0);
`ifdef GRILL_TICK_EDGE_EN
    chk("lv_latency", 32'(cook_cnt), 32'd0);
`else
    chk("lv_latency", 32'(cook_cnt), 32'd1);
`endif
    for (int i = 1; i < 5; i++) step("lv_hold", 0, 1, 0, 0, 0);
    step("lv_rel", 0, 0, 0, 0, 0);
    step("lv_rel2", 0, 0, 0, 0, 0);
`ifdef GRILL_TICK_EDGE_EN
    chk("lv_count", 32'(cook_cnt), 32'd1);
`else
    chk("lv_count", 32'(state), 32'd4);
`endif

    // randomized traffic
    step("rnd_reset", 1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
